riscv_dmem_ctrl: RTL and testbench
==================================

// Module: riscv_dmem_ctrl
// PURPOSE
//  Parametrised data-memory controller for the RISC-V pipeline MEM stage.
//  Accepts one load/store request at a time through a valid/ready handshake.
//  Performs RV32 sub-word access: LB/LH/LW/LBU/LHU and SB/SH/SW.
//  Inserts a configurable number of wait states and flags misaligned or illegal accesses.
//  Drives the wr/rd/addr/wr_data/rd_data trace outputs of the CPU top.
// PARAMETERS
//  DATA_W   32  data word width; only 32 is supported (elaboration error otherwise)
//  ADDR_W   11  byte-address width; array holds DEPTH = 2**(ADDR_W-2) words
//  LATENCY  0   wait states before commit, 0..7
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high reset
//  req_valid  in   1       request present
//  req_ready  out  1       controller can accept a request
//  req_we     in   1       1 = store, 0 = load
//  req_funct3 in   3       RISC-V funct3 access size/sign
//  req_addr   in   ADDR_W  byte address
//  req_wdata  in   DATA_W  store data; low bytes are used
//  rsp_valid  out  1       one-cycle response pulse
//  rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors
//  rsp_err    out  1       misaligned or illegal funct3, valid with rsp_valid
//  wr         out  1       trace: array write committed
//  rd         out  1       trace: array read committed
//  addr       out  ADDR_W  trace: word-aligned byte address of the commit
//  wr_data    out  DATA_W  trace: merged word written
//  rd_data    out  DATA_W  trace: raw word read
// BEHAVIOUR
//  - Reset (asynchronous) forces state IDLE and req_ready=1.
//    All other outputs go to 0. Array contents are not reset.
//  - FSM states: IDLE, WAIT, RESP.
//    - IDLE: req_ready=1. Accept on req_valid&&req_ready; capture all req_* fields.
//      Go to WAIT if LATENCY>0 and the request is legal; otherwise go to RESP.
//    - WAIT: req_ready=0. A 3-bit counter counts LATENCY cycles, then goes to RESP.
//    - RESP: req_ready=0. rsp_valid=1 for exactly one cycle, then back to IDLE.
//  - Legal timing: accept in cycle 0; commit on the edge entering RESP.
//    rsp_valid is high in cycle LATENCY+1; req_ready returns in cycle LATENCY+2.
//  - Error timing: an error goes straight to RESP, so rsp_valid is in cycle 1.
//  - funct3 decode:
//    - 000 = byte, 001 = half, 010 = word.
//    - 100 = unsigned byte, 101 = unsigned half; load only.
//    - Other codes, or 1xx with req_we=1, are illegal: rsp_err=1.
//  - Misalignment: a half with addr[0]=1, or a word with addr[1:0]!=0, gives rsp_err=1.
//  - Error response: no array access, wr=rd=0, rsp_rdata=0.
//  - Store: byte lanes are selected by addr[1:0], little-endian.
//    SB writes lane addr[1:0] with wdata[7:0]. SH writes lanes addr[1]*2+{0,1} with wdata[15:0].
//    Unselected bytes are preserved (read-modify-write within the commit edge).
//  - Load: the lane is extracted from the word at addr[ADDR_W-1:2].
//    Sign-extend for 000/001; zero-extend for 100/101.
//  - Trace outputs are registered with the commit.
//    They are valid in the same cycle as rsp_valid and 0 in every other cycle.
//    addr = {req_addr[ADDR_W-1:2],2'b00}.
//  - req_valid while req_ready=0 is ignored. The requester holds its request until accepted.
//  - Reset mid-operation drops the pending request.
//    An uncommitted store never reaches the array, and no response is issued.
// TESTING
//  1. LATENCY=0: SW 0xDEADBEEF @0x010, then LW @0x010.
//     Expect rsp_rdata=0xDEADBEEF, rsp_valid in cycle 1, rd=1, addr=0x010.
//  2. SB 0x7F @0x013, then LB @0x013 -> 0x0000007F.
//     SB 0x80 @0x012, then LB @0x012 -> 0xFFFFFF80 and LBU @0x012 -> 0x00000080.
//     LW @0x010 -> 0x7F80BEEF.
//  3. SH 0xA5A5 @0x022, then LH @0x022 -> 0xFFFFA5A5 and LHU @0x022 -> 0x0000A5A5.
//     Bytes @0x020..0x021 are unchanged.
//  4. LH @0x021 and SW @0x016: rsp_err=1, rsp_rdata=0, wr=rd=0, array unchanged.
//     funct3=011 also gives rsp_err=1.
//  5. LATENCY=3: SW accepted in cycle 0.
//     Expect req_ready=0 in cycles 1..4, rsp_valid in cycle 4, req_ready=1 in cycle 5.
//  6. LATENCY=3: SW 0x11223344 @0x040, reset pulsed in cycle 2.
//     Expect no rsp_valid and all outputs 0; a later LW @0x040 returns the old contents.

Source files
------------

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory controller for the RV32 MEM stage: one request at a time, sub-word
// load/store with sign/zero extension, configurable wait states and error flagging.
module riscv_dmem_ctrl #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned LATENCY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              wr,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);
    localparam int unsigned WADDR_W = ADDR_W - 2;
    localparam int unsigned DEPTH   = 2 ** WADDR_W;

    if (DATA_W != 32) begin : g_bad_data_w
        $error("riscv_dmem_ctrl: only DATA_W = 32 is supported");
    end
    if (LATENCY > 7) begin : g_bad_latency
        $error("riscv_dmem_ctrl: LATENCY must be 0..7");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                cap_we_q, cap_we_d;
    logic [2:0]          cap_f3_q, cap_f3_d;
    logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
    logic [DATA_W-1:0]   cap_wdata_q, cap_wdata_d;
    logic                req_ready_q, rsp_valid_q, rsp_err_q, wr_q, rd_q;
    logic [DATA_W-1:0]   rsp_rdata_q, wr_data_q, rd_data_q;
    logic [ADDR_W-1:0]   addr_q;

    logic [DATA_W-1:0]   mem [DEPTH];

    // While idle the live request is evaluated so a zero-latency commit can happen at accept.
    logic                cur_we;
    logic [2:0]          cur_f3;
    logic [ADDR_W-1:0]   cur_addr;
    logic [DATA_W-1:0]   cur_wdata;
    logic [WADDR_W-1:0]  word_idx;
    logic [1:0]          lane;
    logic [DATA_W-1:0]   rd_word, load_data, merged, wbytes;
    logic [3:0]          wmask;
    logic [7:0]          byte_v;
    logic [15:0]         half_v;
    logic                f3_ok, misal, cur_err, commit_c, rsp_c;

    assign cur_we    = (state_q == IDLE) ? req_we     : cap_we_q;
    assign cur_f3    = (state_q == IDLE) ? req_funct3 : cap_f3_q;
    assign cur_addr  = (state_q == IDLE) ? req_addr   : cap_addr_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata  : cap_wdata_q;
    assign word_idx  = cur_addr[ADDR_W-1:2];
    assign lane      = cur_addr[1:0];
    assign rd_word   = mem[word_idx];

    // funct3 legality and alignment
    always_comb begin
        f3_ok = 1'b0;
        misal = 1'b0;
        case (cur_f3)
            3'b000: f3_ok = 1'b1;
            3'b001: begin f3_ok = 1'b1;     misal = cur_addr[0];    end
            3'b010: begin f3_ok = 1'b1;     misal = |cur_addr[1:0]; end
            3'b100: f3_ok = !cur_we;
            3'b101: begin f3_ok = !cur_we;  misal = cur_addr[0];    end
            default: f3_ok = 1'b0;
        endcase
        cur_err = !f3_ok || misal;
    end

    // Load lane extraction and store lane merge
    always_comb begin
        byte_v = 8'(rd_word >> {lane, 3'b000});
        half_v = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (cur_f3)
            3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_data = {{16{half_v[15]}}, half_v};
            3'b100:  load_data = {24'd0, byte_v};
            3'b101:  load_data = {16'd0, half_v};
            default: load_data = rd_word;
        endcase
        case (cur_f3[1:0])
            2'b00: begin wmask = 4'b0001 << lane; wbytes = {4{cur_wdata[7:0]}}; end
            2'b01: begin wmask = cur_addr[1] ? 4'b1100 : 4'b0011; wbytes = {2{cur_wdata[15:0]}}; end
            default: begin wmask = 4'b1111; wbytes = cur_wdata; end
        endcase
        merged = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (wmask[i]) merged[i*8 +: 8] = wbytes[i*8 +: 8];
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_we_d    = cap_we_q;
        cap_f3_d    = cap_f3_q;
        cap_addr_d  = cap_addr_q;
        cap_wdata_d = cap_wdata_q;
        commit_c    = 1'b0;
        rsp_c       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cap_we_d    = req_we;
                    cap_f3_d    = req_funct3;
                    cap_addr_d  = req_addr;
                    cap_wdata_d = req_wdata;
                    if (LATENCY > 0 && !cur_err) begin
                        state_d = WAIT;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d  = RESP;
                        rsp_c    = 1'b1;
                        commit_c = !cur_err;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'(LATENCY - 1)) begin
                    state_d  = RESP;
                    rsp_c    = 1'b1;
                    commit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            cap_we_q    <= 1'b0;
            cap_f3_q    <= 3'd0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_we_q    <= cap_we_d;
            cap_f3_q    <= cap_f3_d;
            cap_addr_q  <= cap_addr_d;
            cap_wdata_q <= cap_wdata_d;
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= rsp_c;
            rsp_err_q   <= rsp_c && cur_err;
            rsp_rdata_q <= (commit_c && !cur_we) ? load_data : '0;
            wr_q        <= commit_c && cur_we;
            rd_q        <= commit_c && !cur_we;
            addr_q      <= commit_c ? {cur_addr[ADDR_W-1:2], 2'b00} : '0;
            wr_data_q   <= (commit_c && cur_we) ? merged : '0;
            rd_data_q   <= (commit_c && !cur_we) ? rd_word : '0;
        end
    end

    // Array is not reset; a write is blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (!reset && commit_c && cur_we) mem[word_idx] <= merged;
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign wr        = wr_q;
    assign rd        = rd_q;
    assign addr      = addr_q;
    assign wr_data   = wr_data_q;
    assign rd_data   = rd_data_q;
endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Directed bench for riscv_dmem_ctrl: zero-latency instance driven from a vector
// table, three-wait-state instance exercised with hand-written timing/reset sequences.
module tb_riscv_dmem_ctrl;
    logic        clk;
    logic        reset0, reset3;
    logic        req_valid0, req_valid3;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [10:0] req_addr;
    logic [31:0] req_wdata;

    logic        ready0, rv0, err0, wr0, rd0;
    logic [31:0] rdata0, wdat0, rdat0;
    logic [10:0] addr0;
    logic        ready3, rv3, err3, wr3, rd3;
    logic [31:0] rdata3, wdat3, rdat3;
    logic [10:0] addr3;

    logic        sel;
    logic        m_ready, m_rv, m_err, m_wr, m_rd;
    logic [31:0] m_rdata, m_wdat, m_rdat;
    logic [10:0] m_addr;

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] trace;
    } vec_t;

    vec_t vecs[$];

    riscv_dmem_ctrl #(.DATA_W(32), .ADDR_W(11), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset0), .req_valid(req_valid0), .req_ready(ready0),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_rdata(rdata0), .rsp_err(err0),
        .wr(wr0), .rd(rd0), .addr(addr0), .wr_data(wdat0), .rd_data(rdat0)
    );

    riscv_dmem_ctrl #(.DATA_W(32), .ADDR_W(11), .LATENCY(3)) dut3 (
        .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_ready(ready3),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv3), .rsp_rdata(rdata3), .rsp_err(err3),
        .wr(wr3), .rd(rd3), .addr(addr3), .wr_data(wdat3), .rd_data(rdat3)
    );

    assign m_ready = sel ? ready3 : ready0;
    assign m_rv    = sel ? rv3    : rv0;
    assign m_err   = sel ? err3   : err0;
    assign m_wr    = sel ? wr3    : wr0;
    assign m_rd    = sel ? rd3    : rd0;
    assign m_rdata = sel ? rdata3 : rdata0;
    assign m_wdat  = sel ? wdat3  : wdat0;
    assign m_rdat  = sel ? rdat3  : rdat0;
    assign m_addr  = sel ? addr3  : addr0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d): got %h, expected %h", name, sel ? 3 : 0, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, 32'(m_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(m_rv), 32'd0);
        chk({tag, "_rsp_err"}, 32'(m_err), 32'd0);
        chk({tag, "_rsp_rdata"}, m_rdata, 32'd0);
        chk({tag, "_wr"}, 32'(m_wr), 32'd0);
        chk({tag, "_rd"}, 32'(m_rd), 32'd0);
        chk({tag, "_addr"}, 32'(m_addr), 32'd0);
        chk({tag, "_wr_data"}, m_wdat, 32'd0);
        chk({tag, "_rd_data"}, m_rdat, 32'd0);
    endtask

    // Issue one request and check every cycle up to the one after the response.
    task automatic run(input logic w, input vec_t v, input int exp_cyc);
        sel = w;
        n_vec++;
        @(negedge clk);
        chk("ready_before", 32'(m_ready), 32'd1);
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        if (w) req_valid3 = 1'b1;
        else   req_valid0 = 1'b1;
        @(posedge clk);
        #1;
        req_valid0 = 1'b0;
        req_valid3 = 1'b0;
        for (int c = 1; c <= exp_cyc + 1; c++) begin
            @(negedge clk);
            if (c < exp_cyc) begin
                chk("ready_busy", 32'(m_ready), 32'd0);
                chk("rsp_early", 32'(m_rv), 32'd0);
            end else if (c == exp_cyc) begin
                chk("ready_in_rsp", 32'(m_ready), 32'd0);
                chk("rsp_valid", 32'(m_rv), 32'd1);
                chk("rsp_err", 32'(m_err), 32'(v.err));
                chk("rsp_rdata", m_rdata, v.rdata);
                chk("wr", 32'(m_wr), 32'(!v.err && v.we));
                chk("rd", 32'(m_rd), 32'(!v.err && !v.we));
                if (!v.err) begin
                    chk("addr", 32'(m_addr), 32'({v.addr[10:2], 2'b00}));
                    if (v.we) chk("wr_data", m_wdat, v.trace);
                    else      chk("rd_data", m_rdat, v.trace);
                end
            end else begin
                chk("ready_after", 32'(m_ready), 32'd1);
                chk("rsp_after", 32'(m_rv), 32'd0);
                chk("wr_after", 32'(m_wr), 32'd0);
                chk("rd_after", 32'(m_rd), 32'd0);
            end
        end
    endtask

    initial begin
        vec_t v;
        //               we    f3      addr     wdata          err   rdata          trace
        vecs.push_back('{1'b1, 3'b010, 11'h010, 32'hDEADBEEF, 1'b0, 32'h00000000, 32'hDEADBEEF});
        vecs.push_back('{1'b0, 3'b010, 11'h010, 32'h00000000, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 3'b000, 11'h013, 32'h0000007F, 1'b0, 32'h00000000, 32'h7FADBEEF});
        vecs.push_back('{1'b0, 3'b000, 11'h013, 32'h00000000, 1'b0, 32'h0000007F, 32'h7FADBEEF});
        vecs.push_back('{1'b1, 3'b000, 11'h012, 32'h12345680, 1'b0, 32'h00000000, 32'h7F80BEEF});
        vecs.push_back('{1'b0, 3'b000, 11'h012, 32'h00000000, 1'b0, 32'hFFFFFF80, 32'h7F80BEEF});
        vecs.push_back('{1'b0, 3'b100, 11'h012, 32'h00000000, 1'b0, 32'h00000080, 32'h7F80BEEF});
        vecs.push_back('{1'b0, 3'b010, 11'h010, 32'h00000000, 1'b0, 32'h7F80BEEF, 32'h7F80BEEF});
        vecs.push_back('{1'b0, 3'b001, 11'h010, 32'h00000000, 1'b0, 32'hFFFFBEEF, 32'h7F80BEEF});
        vecs.push_back('{1'b0, 3'b001, 11'h012, 32'h00000000, 1'b0, 32'h00007F80, 32'h7F80BEEF});
        vecs.push_back('{1'b1, 3'b010, 11'h020, 32'h12345678, 1'b0, 32'h00000000, 32'h12345678});
        vecs.push_back('{1'b1, 3'b001, 11'h022, 32'hFFFFA5A5, 1'b0, 32'h00000000, 32'hA5A55678});
        vecs.push_back('{1'b0, 3'b001, 11'h022, 32'h00000000, 1'b0, 32'hFFFFA5A5, 32'hA5A55678});
        vecs.push_back('{1'b0, 3'b101, 11'h022, 32'h00000000, 1'b0, 32'h0000A5A5, 32'hA5A55678});
        vecs.push_back('{1'b0, 3'b010, 11'h020, 32'h00000000, 1'b0, 32'hA5A55678, 32'hA5A55678});
        vecs.push_back('{1'b0, 3'b001, 11'h021, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000});
        vecs.push_back('{1'b1, 3'b010, 11'h016, 32'hCAFEF00D, 1'b1, 32'h00000000, 32'h00000000});
        vecs.push_back('{1'b0, 3'b011, 11'h010, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000});
        vecs.push_back('{1'b1, 3'b100, 11'h010, 32'h000000AA, 1'b1, 32'h00000000, 32'h00000000});
        vecs.push_back('{1'b0, 3'b110, 11'h010, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000});
        vecs.push_back('{1'b0, 3'b010, 11'h010, 32'h00000000, 1'b0, 32'h7F80BEEF, 32'h7F80BEEF});
        vecs.push_back('{1'b0, 3'b010, 11'h014, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000});

        sel        = 1'b0;
        reset0     = 1'b1;
        reset3     = 1'b1;
        req_valid0 = 1'b0;
        req_valid3 = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = '0;
        req_wdata  = '0;

        #12;
        sel = 1'b0; chk_idle_outputs("reset");
        sel = 1'b1; chk_idle_outputs("reset");
        @(negedge clk);
        reset0 = 1'b0;
        reset3 = 1'b0;

        // Word 0x014 is written before the final table entry reads it back.
        begin
            vec_t z;
            z = '{1'b1, 3'b010, 11'h014, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000};
            run(1'b0, z, 1);
        end

        for (int i = 0; i < vecs.size(); i++) run(1'b0, vecs[i], vecs[i].err ? 1 : 1);

        // Three wait states: legal accesses respond in cycle 4, errors in cycle 1.
        v = '{1'b1, 3'b010, 11'h040, 32'hAABBCCDD, 1'b0, 32'h00000000, 32'hAABBCCDD};
        run(1'b1, v, 4);
        v = '{1'b0, 3'b010, 11'h040, 32'h00000000, 1'b0, 32'hAABBCCDD, 32'hAABBCCDD};
        run(1'b1, v, 4);
        v = '{1'b0, 3'b001, 11'h041, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000};
        run(1'b1, v, 1);
        v = '{1'b1, 3'b000, 11'h043, 32'h00000011, 1'b0, 32'h00000000, 32'h11BBCCDD};
        run(1'b1, v, 4);

        // Reset in cycle 2 of a pending store: no response, no array write.
        sel = 1'b1;
        n_vec++;
        @(negedge clk);
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 11'h040;
        req_wdata  = 32'h11223344;
        req_valid3 = 1'b1;
        @(posedge clk);
        #1;
        req_valid3 = 1'b0;
        @(negedge clk);
        chk("midop_busy", 32'(m_ready), 32'd0);
        @(negedge clk);
        reset3 = 1'b1;
        #1;
        chk_idle_outputs("midop_reset");
        @(negedge clk);
        reset3 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("midop_no_rsp", 32'(m_rv), 32'd0);
            chk("midop_no_wr", 32'(m_wr), 32'd0);
        end
        v = '{1'b0, 3'b010, 11'h040, 32'h00000000, 1'b0, 32'h11BBCCDD, 32'h11BBCCDD};
        run(1'b1, v, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
